// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared opcodes, ALU-op / write-back encodings and FSM states
//               for the multicycle RV32I main controller.
// Revision    : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

   // RV32I major opcodes handled by the controller
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // ALU operation select (base 2-bit encoding)
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RFUNC = 2'b10;
   localparam logic [1:0] ALU_IFUNC = 2'b11;

   // Register write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // Controller states, one per cycle of the multicycle sequence
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ALUWB  = 4'd3,
      S_ADDR   = 4'd4,
      S_MEMRD  = 4'd5,
      S_MEMWB  = 4'd6,
      S_MEMWR  = 4'd7,
      S_BRANCH = 4'd8,
      S_JAL    = 4'd9,
      S_TRAP   = 4'd10
   } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts consecutive memory wait cycles and flags a timeout
//               when ready is still low once TIMEOUT cycles have elapsed.
// Revision    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wait_en_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count_q;
   logic [7:0] count_d;
   logic       stalled;

   // A stalled cycle is a memory-phase cycle without ready; anything else
   // means the state moves on, so the count restarts from zero.
   always_comb begin
      stalled   = wait_en_i && !ready_i;
      timeout_o = stalled && (count_q == LIMIT);
      count_d   = 8'd0;
      if (stalled && (count_q != LIMIT)) begin
         count_d = count_q + 8'd1;
      end
   end

   // Wait counter register, cleared by the active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Sequenced main controller for the multicycle RV32I datapath
//               with memory handshake, flush, timeout and illegal-op traps.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 2,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [6:0]         op_i,
   input  logic               zero_i,
   input  logic               flush_i,
   input  logic               mem_ready_i,
   output logic               pc_write_o,
   output logic               pc_src_o,
   output logic               ir_write_o,
   output logic               iord_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               alu_src_a_o,
   output logic               alu_src_b_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               reg_write_o,
   output logic [1:0]         wb_sel_o,
   output logic               illegal_o,
   output logic               bus_err_o,
   output logic [CNT_W-1:0]   instret_o,
   output logic               busy_o
);

   state_e             state_q, state_d;
   logic               is_imm_q, is_imm_d;    // decoded I-type ALU op
   logic               is_load_q, is_load_d;  // decoded load vs store
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               retire;
   logic               wait_en;
   logic               timeout;
   logic [1:0]         alu_op;

   assign wait_en = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wait_en_i (wait_en),
      .ready_i   (mem_ready_i),
      .timeout_o (timeout)
   );

   assign alu_op_o  = ALUOP_W'(alu_op);
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;
   assign instret_o = instret_q;
   assign busy_o    = (state_q != S_FETCH);

   // Next-state, decoded-class latches, traps and per-state control strobes
   always_comb begin
      state_d     = state_q;
      is_imm_d    = is_imm_q;
      is_load_d   = is_load_q;
      illegal_d   = illegal_q;
      bus_err_d   = bus_err_q;
      retire      = 1'b0;
      pc_write_o  = 1'b0;
      pc_src_o    = 1'b0;
      ir_write_o  = 1'b0;
      iord_o      = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      alu_src_a_o = 1'b0;
      alu_src_b_o = 1'b0;
      alu_op      = ALU_ADD;
      reg_write_o = 1'b0;
      wb_sel_o    = WB_ALU;
      case (state_q)
         S_FETCH: begin
            mem_read_o = 1'b1;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_DECODE: begin
            // Branch/jump target is precomputed here from old PC + imm
            alu_src_a_o = 1'b1;
            alu_src_b_o = 1'b1;
            if (flush_i) begin
               state_d = S_FETCH;
            end else begin
               case (op_i)
                  OP_R:   begin state_d = S_EXEC;   is_imm_d  = 1'b0; end
                  OP_I:   begin state_d = S_EXEC;   is_imm_d  = 1'b1; end
                  OP_LW:  begin state_d = S_ADDR;   is_load_d = 1'b1; end
                  OP_SW:  begin state_d = S_ADDR;   is_load_d = 1'b0; end
                  OP_BEQ: state_d = S_BRANCH;
                  OP_JAL: state_d = S_JAL;
                  default: begin
                     state_d   = S_TRAP;
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end
         S_EXEC: begin
            alu_src_b_o = is_imm_q;
            alu_op      = is_imm_q ? ALU_IFUNC : ALU_RFUNC;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_o = 1'b1;
            wb_sel_o    = WB_ALU;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_ADDR: begin
            alu_src_b_o = 1'b1;
            alu_op      = ALU_ADD;
            state_d     = is_load_q ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
            if (mem_ready_i) begin
               state_d = S_MEMWB;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_MEMWB: begin
            reg_write_o = 1'b1;
            wb_sel_o    = WB_MEM;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
            if (mem_ready_i) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_BRANCH: begin
            alu_op     = ALU_SUB;
            pc_write_o = zero_i;
            pc_src_o   = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            reg_write_o = 1'b1;
            wb_sel_o    = WB_PC4;
            pc_write_o  = 1'b1;
            pc_src_o    = 1'b1;
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
   end

   // State and status registers; reset overrides everything, including TRAP
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= S_FETCH;
         is_imm_q  <= 1'b0;
         is_load_q <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         is_imm_q  <= is_imm_d;
         is_load_q <= is_load_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         instret_q <= instret_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- FSM-based main control for the multicycle RV32I datapath. It replaces the single-cycle opcode decoder with a sequenced controller that shares one memory port for instruction and data.
- Drives PC/IR write enables, ALU operand and operation selects, memory request and write-back select, one state per cycle.
- Adds a memory ready handshake, a flush/no-op squash, a memory timeout, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- ALUOP_W, 2, width of alu_op_o. Values above 2 zero-extend the encodings given below.
- TIMEOUT, 15, maximum cycles to wait for mem_ready_i before raising bus_err_o. Range 1..255.
- CNT_W, 32, width of the instret_o counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- op_i  in  7  opcode field of the instruction register
- zero_i  in  1  ALU zero flag (valid in BRANCH)
- flush_i  in  1  squash the instruction currently in DECODE
- mem_ready_i  in  1  memory accepts/completes the current request this cycle
- pc_write_o  out  1  PC register load
- pc_src_o  out  1  0 = PC+4, 1 = ALU result (branch/jump target)
- ir_write_o  out  1  instruction register and old-PC load
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- alu_src_a_o  out  1  0 = rs1, 1 = old PC
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- alu_op_o  out  ALUOP_W  00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
- reg_write_o  out  1  register file write
- wb_sel_o  out  2  00 ALU result, 01 memory data, 10 PC+4
- illegal_o  out  1  sticky illegal-opcode trap
- bus_err_o  out  1  sticky memory timeout trap
- instret_o  out  CNT_W  retired instruction count
- busy_o  out  1  high in every state except FETCH

Behaviour:
- Reset (rst_i==0 at a posedge):
  - State goes to FETCH; wait counter, instret_o, illegal_o and bus_err_o clear to 0.
  - Reset has priority over every other input, including mid-memory-wait and trap states.
- Outputs are a Moore function of state, except the ready-qualified strobes noted below. Every control output not listed for a state is 0.
- States:
  - FETCH: mem_read_o=1, iord_o=0.
    - If mem_ready_i: ir_write_o=1, pc_write_o=1, pc_src_o=0, go to DECODE.
    - Otherwise stay in FETCH.
  - DECODE: alu_src_a_o=1, alu_src_b_o=1, alu_op_o=00 (precompute branch/jump target).
    - If flush_i: go to FETCH, not retired.
    - Otherwise dispatch on op_i: 0110011 and 0010011 go to EXEC; 0000011 and 0100011 go to ADDR; 1100011 goes to BRANCH; 1101111 goes to JAL; any other opcode goes to TRAP with illegal_o set.
  - EXEC: alu_src_b_o = (op==0010011), alu_op_o = 10 for R-type, 11 for I-type. Go to ALUWB.
  - ALUWB: reg_write_o=1, wb_sel_o=00. Retire, go to FETCH.
  - ADDR: alu_src_b_o=1, alu_op_o=00. Go to MEMRD for a load, MEMWR for a store.
  - MEMRD: mem_read_o=1, iord_o=1. Go to MEMWB on mem_ready_i.
  - MEMWB: reg_write_o=1, wb_sel_o=01. Retire, go to FETCH.
  - MEMWR: mem_write_o=1, iord_o=1. On mem_ready_i, retire and go to FETCH.
  - BRANCH: alu_op_o=01. pc_write_o=zero_i, pc_src_o=1. Retire, go to FETCH.
  - JAL: reg_write_o=1, wb_sel_o=10, pc_write_o=1, pc_src_o=1. Retire, go to FETCH.
  - TRAP: all strobes 0, busy_o=1. Held until reset.
- Latencies with zero wait states:
  - ALU op: 4 cycles; load: 5; store: 4; branch: 3; jal: 3.
  - Each memory wait cycle adds 1.
- Memory wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready_i==0; clears on any state change.
  - When the count reaches TIMEOUT while ready is still low, the next state is TRAP with bus_err_o=1.
  - mem_ready_i arriving in the same cycle the count reaches TIMEOUT wins: normal transition, no error.
- The opcode is decoded only in DECODE (from the stable IR); op_i changes in other states are ignored.
- flush_i is ignored outside DECODE.
- instret_o increments by 1 on each retire and wraps modulo 2^CNT_W.
- Only one of mem_read_o and mem_write_o is ever high at a time.

Decomposition:
- Shared package (riscv_ctrl_pkg):
  - Opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL.
  - ALU-op encodings and wb_sel encodings.
  - State enum typedef.
- One sub-module, mem_wait_timer, holding the wait counter and the timeout compare. The FSM and output decode stay in the top.

Test Plan:
- Reset release, R-type 0110011 with ready held high -> states FETCH, DECODE, EXEC, ALUWB; reg_write_o pulses in cycle 4; instret_o=1.
- Load 0000011 with 3 wait cycles in MEMRD -> completes in 8 cycles; MEMWB has wb_sel_o=01 and reg_write_o=1.
- BEQ with zero_i=1, then BEQ with zero_i=0 -> first case pc_write_o=1 and pc_src_o=1 in BRANCH; second case pc_write_o=0; instret_o increments both times.
- op_i=0001111 in DECODE -> TRAP; illegal_o=1 held for 20 cycles with no strobes; rst_i low for one edge clears it and returns to FETCH.
- mem_ready_i held low in MEMWR for TIMEOUT cycles -> bus_err_o=1. Repeat with ready asserted exactly at count TIMEOUT -> no error, returns to FETCH.
- flush_i=1 in DECODE on an SW -> returns to FETCH, no mem_write_o, instret_o unchanged. Separately, rst_i low during a FETCH wait aborts to FETCH with all counters cleared.
